expansion: RTL and testbench

EXPANSION -- requirements
Module: expansion

---
 rtl/expansion.sv | 132 +++++++++++++
 tb/tb_expansion.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/expansion.sv
// ============================================================================
//  Module   : expansion
//  Purpose  : Envelope-driven downward expander, one sample per 5-cycle pass.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module expansion #(
    parameter int SAMPLING_RATE = 24000,
    parameter int THRESH_LOG2   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [11:0] incoming_sample,
    input  logic        [1:0]  expansion_amount,
    input  logic               enable,
    output logic signed [11:0] modified_sample,
    output logic               done,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENVELOPE = 3'd1,
        GAIN     = 3'd2,
        APPLY    = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [10:0] THRESH  = 11'(1 << THRESH_LOG2);
    localparam logic [4:0]  T_WIDTH = 5'(THRESH_LOG2);

    // SAMPLING_RATE is informational; no logic depends on it.
    if (SAMPLING_RATE <= 0) begin : g_rate_informational
    end

    state_t             state;
    state_t             next_state;
    logic signed [11:0] x_lat;
    logic        [1:0]  amt_lat;
    logic               en_lat;
    logic        [10:0] env;
    logic        [3:0]  shift;

    logic        [11:0] neg_x;
    logic        [10:0] mag;
    logic        [10:0] rel_diff;
    logic        [10:0] rel_step;
    logic        [10:0] env_next;
    logic        [3:0]  msb;
    logic        [4:0]  diff5;
    logic        [6:0]  prod;
    logic        [3:0]  shift_next;
    logic signed [11:0] shifted;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = ENVELOPE;
            ENVELOPE: next_state = GAIN;
            GAIN:     next_state = APPLY;
            APPLY:    next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Magnitude saturates -2048 to 2047; release step never underflows env.
    always_comb begin
        neg_x    = -x_lat;
        mag      = (x_lat == 12'sh800) ? 11'd2047
                 : (x_lat[11] ? neg_x[10:0] : x_lat[10:0]);
        rel_diff = env - mag;
        rel_step = rel_diff >> 4;
        if (mag >= env)
            env_next = mag;
        else if (rel_step != 11'd0)
            env_next = env - rel_step;
        else
            env_next = env - 11'd1;
    end

    always_comb begin
        msb = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (env[i]) msb = 4'(i);
        end
        diff5 = (env == 11'd0) ? (T_WIDTH + 5'd1) : (T_WIDTH - {1'b0, msb});
        prod  = {2'b00, diff5} * {5'b00000, amt_lat};
        if (env >= THRESH || !en_lat || amt_lat == 2'b00)
            shift_next = 4'd0;
        else if (prod > 7'd11)
            shift_next = 4'd11;
        else
            shift_next = prod[3:0];
        shifted = x_lat >>> shift;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            x_lat           <= '0;
            amt_lat         <= '0;
            en_lat          <= 1'b0;
            env             <= '0;
            shift           <= '0;
            modified_sample <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_lat   <= incoming_sample;
                        amt_lat <= expansion_amount;
                        en_lat  <= enable;
                    end
                end
                ENVELOPE: env   <= env_next;
                GAIN:     shift <= shift_next;
                APPLY:    modified_sample <= (shift >= 4'd11) ? 12'sd0 : shifted;
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_expansion.sv
// Self-checking bench for expansion: directed cases plus random samples
// compared against an arithmetic reference model of the expander.
`timescale 1ns/1ps

module tb_expansion;

    localparam int T = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               enable = 1'b0;
    logic signed [11:0] incoming_sample = '0;
    logic        [1:0]  expansion_amount = '0;
    logic signed [11:0] modified_sample;
    logic               done;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_env = 0;

    expansion #(.SAMPLING_RATE(24000), .THRESH_LOG2(T)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .incoming_sample  (incoming_sample),
        .expansion_amount (expansion_amount),
        .enable           (enable),
        .modified_sample  (modified_sample),
        .done             (done),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: envelope follower, log2 gain, floor-division shift.
    function automatic int model_step(input int x, input int amt, input bit en);
        int mag, d, p, sh, div;
        mag = (x < 0) ? -x : x;
        if (mag > 2047) mag = 2047;
        if (mag >= model_env) model_env = mag;
        else begin
            d = (model_env - mag) / 16;
            model_env = model_env - ((d > 0) ? d : 1);
        end
        if (!en || amt == 0 || model_env >= (2 ** T)) return x;
        p = -1;
        for (int i = 0; i < 11; i++) if (model_env >= (2 ** i)) p = i;
        sh = (T - p) * amt;
        if (sh >= 11) return 0;
        div = 2 ** sh;
        return (x >= 0) ? x / div : -((-x + div - 1) / div);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_env = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_op(input int x, input int amt, input bit en, input string tag);
        int exp_out, lat;
        bit seen;
        @(negedge clock);
        start = 1'b1;
        incoming_sample  = 12'(x);
        expansion_amount = 2'(amt);
        enable = en;
        exp_out = model_step(x, amt, en);
        @(posedge clock); #1;
        start = 1'b0;
        incoming_sample  = 12'($urandom);
        expansion_amount = 2'($urandom);
        enable = 1'($urandom);
        check_eq({tag, " busy"}, int'(busy), 1);
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        check_eq({tag, " latency"}, lat, 4);
        check_eq({tag, " out"}, int'(modified_sample), exp_out);
        @(posedge clock); #1;
        check_eq({tag, " done_low"}, int'(done), 0);
        check_eq({tag, " busy_low"}, int'(busy), 0);
        check_eq({tag, " hold"}, int'(modified_sample), exp_out);
    endtask

    task automatic start_in_gain();
        int exp_out, pulses;
        @(negedge clock);
        start = 1'b1; incoming_sample = 12'sd200; expansion_amount = 2'b01; enable = 1'b1;
        exp_out = model_step(200, 1, 1'b1);
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; incoming_sample = -12'sd1500; expansion_amount = 2'b11;
        @(posedge clock); #1;
        start = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (done) begin
                pulses++;
                check_eq("gain_start out", int'(modified_sample), exp_out);
            end
        end
        check_eq("gain_start pulses", pulses, 1);
    endtask

    task automatic reset_in_apply();
        int pulses;
        @(negedge clock);
        start = 1'b1; incoming_sample = 12'sd1500; expansion_amount = 2'b01; enable = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        model_env = 0;
        #1;
        check_eq("abort out", int'(modified_sample), 0);
        check_eq("abort done", int'(done), 0);
        check_eq("abort busy", int'(busy), 0);
        start = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done || busy) pulses++;
        end
        check_eq("start in reset", pulses, 0);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        run_op(10, 1, 1'b1, "post_abort");
    endtask

    initial begin
        int x, amt;
        bit en;
        #1;
        check_eq("rst out", int'(modified_sample), 0);
        check_eq("rst done", int'(done), 0);
        check_eq("rst busy", int'(busy), 0);
        start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst start_ignored", int'(busy), 0);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;

        run_op(1000, 1, 1'b1, "unity1000");
        do_reset();
        run_op(-100, 1, 1'b1, "neg100_a1");
        do_reset();
        run_op(-100, 3, 1'b1, "neg100_a3");
        do_reset();
        run_op(300, 1, 1'b1, "rel300");
        run_op(64, 1, 1'b1, "rel64");
        run_op(-2048, 2, 1'b1, "sat2048");
        run_op(-5, 1, 1'b0, "bypass_en");
        run_op(-5, 0, 1'b1, "bypass_amt");
        start_in_gain();
        reset_in_apply();

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 0) x = int'($urandom_range(0, 4095)) - 2048;
            else x = int'($urandom_range(0, 600)) - 300;
            amt = int'($urandom_range(0, 3));
            en  = ($urandom_range(0, 7) != 0);
            run_op(x, amt, en, "rand");
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
